// File: rtl/rx_bit_timer.sv
// UART receive bit timer: after an accepted start, issues one shift_strobe per frame bit at a
// configurable point in each bit window, then a single packet_done pulse.
module rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned START_DELAY  = 2,
  parameter int unsigned STROBE_POS   = 10,
  localparam int unsigned N     = DATA_BITS + PARITY_EN + STOP_BITS,
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1),
  localparam int unsigned IDX_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             shift_strobe,
  output logic             packet_done,
  output logic             busy,
  output logic [IDX_W-1:0] bit_index
);

  localparam logic [CNT_W-1:0] CntMax    = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CntStrobe = CNT_W'(STROBE_POS);
  localparam logic [IDX_W-1:0] LastBit   = IDX_W'(N);
  localparam logic [2:0]       DelayLast = 3'(START_DELAY);
  localparam logic             FirstHit  = (STROBE_POS == 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRun, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       dly_q;

  // Clock counter runs 1..CLKS_PER_BIT and wraps back to 1.
  always_comb begin
    cnt_nxt = CNT_W'(1);
    if (cnt_q != CntMax) cnt_nxt = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      dly_q        <= '0;
      shift_strobe <= 1'b0;
      packet_done  <= 1'b0;
      busy         <= 1'b0;
      bit_index    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          shift_strobe <= 1'b0;
          packet_done  <= 1'b0;
          bit_index    <= '0;
          if (start) begin
            busy <= 1'b1;
            if (START_DELAY == 0) begin
              state_q      <= StRun;
              cnt_q        <= CNT_W'(1);
              shift_strobe <= FirstHit;
              bit_index    <= IDX_W'(FirstHit);
            end else begin
              state_q <= StDelay;
              dly_q   <= 3'd1;
            end
          end
        end
        StDelay: begin
          if (dly_q == DelayLast) begin
            state_q      <= StRun;
            dly_q        <= '0;
            cnt_q        <= CNT_W'(1);
            shift_strobe <= FirstHit;
            bit_index    <= IDX_W'(FirstHit);
          end else begin
            dly_q <= dly_q + 3'd1;
          end
        end
        StRun: begin
          // The last strobe ends the frame; the rest of that bit window is not timed.
          if (shift_strobe && (bit_index == LastBit)) begin
            state_q      <= StDone;
            cnt_q        <= '0;
            shift_strobe <= 1'b0;
            packet_done  <= 1'b1;
          end else begin
            cnt_q        <= cnt_nxt;
            shift_strobe <= (cnt_nxt == CntStrobe);
            bit_index    <= bit_index + IDX_W'(cnt_nxt == CntStrobe);
          end
        end
        StDone: begin
          state_q     <= StIdle;
          packet_done <= 1'b0;
          busy        <= 1'b0;
          bit_index   <= '0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Bench for rx_bit_timer: three parameterisations checked every cycle against a frame-timing
// model derived from the accepted-start cycle, plus hand-computed pinned values.
module tb_rx_bit_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, st_a, ab_a, st_bc, ab_bc;

  logic       ss_a, pd_a, bz_a;
  logic [3:0] bi_a;
  logic       ss_b, pd_b, bz_b;
  logic [3:0] bi_b;
  logic       ss_c, pd_c, bz_c;
  logic [3:0] bi_c;

  // A: defaults, N=9
  rx_bit_timer u_a (
    .clk(clk), .rst(rst), .start(st_a), .abort(ab_a),
    .shift_strobe(ss_a), .packet_done(pd_a), .busy(bz_a), .bit_index(bi_a)
  );
  // B: 16 clocks/bit, mid-bit sampling, parity, two stops -> N=11
  rx_bit_timer #(
    .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(2),
    .START_DELAY(2), .STROBE_POS(8)
  ) u_b (
    .clk(clk), .rst(rst), .start(st_bc), .abort(ab_bc),
    .shift_strobe(ss_b), .packet_done(pd_b), .busy(bz_b), .bit_index(bi_b)
  );
  // C: no start delay
  rx_bit_timer #(.START_DELAY(0)) u_c (
    .clk(clk), .rst(rst), .start(st_bc), .abort(ab_bc),
    .shift_strobe(ss_c), .packet_done(pd_c), .busy(bz_c), .bit_index(bi_c)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int cyc, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected outputs k cycles after the accepted start (fs < 0: no frame).
  task automatic model(input int fs, input int cyc, input int d, input int sp, input int c,
                       input int n, output int busy, output int strobe, output int done,
                       output int idx);
    int k, first, last;
    busy = 0; strobe = 0; done = 0; idx = 0;
    if (fs >= 0) begin
      k     = cyc - fs;
      first = d + sp;
      last  = first + (n - 1) * c + 1;
      if (k >= 1 && k <= last) begin
        busy   = 1;
        done   = (k == last) ? 1 : 0;
        strobe = (k >= first && k < last && (k - first) % c == 0) ? 1 : 0;
        if (k >= first) idx = ((k - first) / c + 1 > n) ? n : (k - first) / c + 1;
      end
    end
  endtask

  task automatic cmp_inst(input string tag, input int fs, input int cyc, input int d,
                          input int sp, input int c, input int n, input logic ss,
                          input logic pd, input logic bz, input logic [3:0] bi,
                          output int exp_busy);
    int eb, es, ed, ei;
    model(fs, cyc, d, sp, c, n, eb, es, ed, ei);
    chk({tag, ".shift_strobe"}, cyc, int'(ss), es);
    chk({tag, ".packet_done"}, cyc, int'(pd), ed);
    chk({tag, ".busy"}, cyc, int'(bz), eb);
    chk({tag, ".bit_index"}, cyc, int'(bi), ei);
    exp_busy = eb;
  endtask

  int fs_a = -1;
  int fs_b = -1;
  int fs_c = -1;

  initial begin
    int eb_a, eb_b, eb_c;
    rst = 1'b1; st_a = 1'b0; ab_a = 1'b0; st_bc = 1'b0; ab_bc = 1'b0;
    for (int cyc = 0; cyc <= 700; cyc++) begin
      @(negedge clk);
      eb_a = 0; eb_b = 0; eb_c = 0;
      if (cyc >= 1) begin
        cmp_inst("A", fs_a, cyc, 2, 10, 10, 9, ss_a, pd_a, bz_a, bi_a, eb_a);
        cmp_inst("B", fs_b, cyc, 2, 8, 16, 11, ss_b, pd_b, bz_b, bi_b, eb_b);
        cmp_inst("C", fs_c, cyc, 0, 10, 10, 9, ss_c, pd_c, bz_c, bi_c, eb_c);
      end
      // Hand-computed pins
      if (cyc == 1)   chk("A.reset_busy", cyc, int'(bz_a), 0);
      if (cyc == 22)  chk("A.first_strobe", cyc, int'(ss_a), 1);
      if (cyc == 22)  chk("A.first_index", cyc, int'(bi_a), 1);
      if (cyc == 102) chk("A.last_index", cyc, int'(bi_a), 9);
      if (cyc == 103) chk("A.done", cyc, int'(pd_a), 1);
      if (cyc == 104) chk("A.busy_low", cyc, int'(bz_a), 0);
      if (cyc == 151) chk("A.abort_index", cyc, int'(bi_a), 0);
      if (cyc == 151) chk("A.abort_busy", cyc, int'(bz_a), 0);
      if (cyc == 167) chk("A.restart_strobe", cyc, int'(ss_a), 1);
      if (cyc == 353) chk("A.b2b_done", cyc, int'(pd_a), 1);
      if (cyc == 366) chk("A.b2b_strobe", cyc, int'(ss_a), 1);
      if (cyc == 448) chk("A.b2b_idle", cyc, int'(bz_a), 0);
      if (cyc == 551) chk("A.rst_busy", cyc, int'(bz_a), 0);
      if (cyc == 653) chk("A.post_rst_done", cyc, int'(pd_a), 1);
      if (cyc == 20)  chk("B.first_strobe", cyc, int'(ss_b), 1);
      if (cyc == 180) chk("B.last_index", cyc, int'(bi_b), 11);
      if (cyc == 181) chk("B.done", cyc, int'(pd_b), 1);
      if (cyc == 20)  chk("C.first_strobe", cyc, int'(ss_c), 1);
      if (cyc == 101) chk("C.done", cyc, int'(pd_c), 1);

      // Drive this cycle's inputs
      rst   = (cyc <= 2) || (cyc == 550);
      st_a  = (cyc == 10) || (cyc == 110) || (cyc == 155) || (cyc >= 260 && cyc < 400) ||
              (cyc == 500) || (cyc == 550) || (cyc == 560);
      ab_a  = (cyc == 150);
      st_bc = (cyc == 10);
      ab_bc = 1'b0;

      // Advance the model with what the next edge samples
      if (rst || ab_a) fs_a = -1;
      else if (st_a && eb_a == 0) fs_a = cyc;
      if (rst || ab_bc) begin
        fs_b = -1;
        fs_c = -1;
      end else if (st_bc) begin
        if (eb_b == 0) fs_b = cyc;
        if (eb_c == 0) fs_c = cyc;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
